// File: rtl/lut_config_loader_if.sv
// Host-side word streams of the LUT configuration loader: configuration words
// in (valid/ready) and readback words out (valid/ready).
`timescale 1ns/1ps
interface lut_config_loader_if #(
    parameter int WORD_WIDTH = 8
);
    logic [WORD_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/lut_config_loader.sv
// Streams host words into a LUT configuration shift chain frame by frame and
// optionally packs the displaced chain contents back into host words.
`timescale 1ns/1ps
module lut_config_loader #(
    parameter int FRAME_WIDTH  = 1,
    parameter int CHAIN_FRAMES = 16,
    parameter int WORD_WIDTH   = 8
) (
    input  logic                   config_clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   readback,
    lut_config_loader_if.slave     host,
    output logic                   config_en,
    output logic [FRAME_WIDTH-1:0] config_in,
    input  logic [FRAME_WIDTH-1:0] config_out,
    output logic                   busy,
    output logic                   done
);
    localparam int unsigned WPF = WORD_WIDTH / FRAME_WIDTH;
    localparam int          FCW = $clog2(CHAIN_FRAMES + 1);
    localparam int          KCW = $clog2(WPF + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [FCW-1:0]        frame_cnt_q, frame_cnt_d;
    logic [KCW-1:0]        word_cnt_q, word_cnt_d;
    logic [KCW-1:0]        cap_cnt_q, cap_cnt_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic [WORD_WIDTH-1:0] cap_q, cap_d;
    logic [WORD_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  rb_q, rb_d;
    logic                  shift_s;
    logic [WORD_WIDTH-1:0] cap_next_s;

    // A shift happens only in SHIFT with frames left and no readback word blocked at the host.
    assign shift_s = (state_q == S_SHIFT) && (frame_cnt_q != FCW'(0))
                     && !(out_valid_q && !host.out_ready);

    // State register and datapath registers.
    always_ff @(posedge config_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            frame_cnt_q <= FCW'(0);
            word_cnt_q  <= KCW'(0);
            cap_cnt_q   <= KCW'(0);
            word_q      <= WORD_WIDTH'(0);
            cap_q       <= WORD_WIDTH'(0);
            out_data_q  <= WORD_WIDTH'(0);
            out_valid_q <= 1'b0;
            rb_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            word_cnt_q  <= word_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            word_q      <= word_d;
            cap_q       <= cap_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            rb_q        <= rb_d;
        end
    end

    // Next-state, frame sequencing and readback packing.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        word_cnt_d  = word_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        word_d      = word_q;
        cap_d       = cap_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        rb_d        = rb_q;
        cap_next_s  = cap_q;

        for (int k = 0; k < int'(WPF); k++) begin
            if (cap_cnt_q == KCW'(k)) begin
                cap_next_s[k*FRAME_WIDTH +: FRAME_WIDTH] = config_out;
            end else begin
                cap_next_s[k*FRAME_WIDTH +: FRAME_WIDTH] = cap_q[k*FRAME_WIDTH +: FRAME_WIDTH];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    frame_cnt_d = FCW'(CHAIN_FRAMES);
                    rb_d        = readback;
                    cap_d       = WORD_WIDTH'(0);
                    cap_cnt_d   = KCW'(0);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (host.in_valid) begin
                    word_d  = host.in_data;
                    state_d = S_SHIFT;
                    // The final word may carry fewer live frames than it holds.
                    if (32'(frame_cnt_q) < WPF) begin
                        word_cnt_d = KCW'(frame_cnt_q);
                    end else begin
                        word_cnt_d = KCW'(WPF);
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_SHIFT: begin
                if (shift_s) begin
                    word_d      = word_q >> FRAME_WIDTH;
                    frame_cnt_d = frame_cnt_q - FCW'(1);
                    word_cnt_d  = word_cnt_q - KCW'(1);
                    if (word_cnt_q != KCW'(1)) begin
                        state_d = S_SHIFT;
                    end else if (frame_cnt_q != FCW'(1)) begin
                        state_d = S_LOAD;
                    end else if (rb_q) begin
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if ((frame_cnt_q == FCW'(0)) && (!out_valid_q || host.out_ready)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (host.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        // A new capture word may land in the same cycle the previous one is taken.
        if (shift_s && rb_q) begin
            if ((cap_cnt_q == KCW'(WPF - 1)) || (frame_cnt_q == FCW'(1))) begin
                out_data_d  = cap_next_s;
                out_valid_d = 1'b1;
                cap_d       = WORD_WIDTH'(0);
                cap_cnt_d   = KCW'(0);
            end else begin
                cap_d     = cap_next_s;
                cap_cnt_d = cap_cnt_q + KCW'(1);
            end
        end else begin
            cap_d = cap_q;
        end
    end

    assign config_en      = shift_s;
    assign config_in      = shift_s ? word_q[FRAME_WIDTH-1:0] : FRAME_WIDTH'(0);
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign host.in_ready  = (state_q == S_LOAD);
    assign host.out_data  = out_data_q;
    assign host.out_valid = out_valid_q;
endmodule

// File: tb/tb_lut_config_loader.sv
// Directed bench for lut_config_loader: a 16-frame and a 12-frame instance,
// each attached to a behavioural 1-bit configuration chain.
`timescale 1ns/1ps
module tb_lut_config_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    lut_config_loader_if #(.WORD_WIDTH(8)) bus16();
    lut_config_loader_if #(.WORD_WIDTH(8)) bus12();

    logic       start16, rb16, en16, busy16, done16;
    logic       start12, rb12, en12, busy12, done12;
    logic [0:0] cin16, cin12;
    logic [15:0] chain16 = 16'h0000;
    logic [11:0] chain12 = 12'h000;

    lut_config_loader #(.FRAME_WIDTH(1), .CHAIN_FRAMES(16), .WORD_WIDTH(8)) dut16 (
        .config_clk(clk), .reset(rst_n), .start(start16), .readback(rb16), .host(bus16),
        .config_en(en16), .config_in(cin16), .config_out(chain16[15]),
        .busy(busy16), .done(done16));

    lut_config_loader #(.FRAME_WIDTH(1), .CHAIN_FRAMES(12), .WORD_WIDTH(8)) dut12 (
        .config_clk(clk), .reset(rst_n), .start(start12), .readback(rb12), .host(bus12),
        .config_en(en12), .config_in(cin12), .config_out(chain12[11]),
        .busy(busy12), .done(done12));

    // Chain models and event recorders.
    logic [255:0] log16 = '0;
    logic [255:0] log12 = '0;
    int nsh16 = 0, nsh12 = 0, ndone16 = 0, ndone12 = 0, acc16 = 0, ov16 = 0, nrx16 = 0;
    logic [7:0] rx16 [0:15];

    always @(posedge clk) begin
        if (en16) begin
            chain16 <= {chain16[14:0], cin16};
            if (nsh16 < 256) log16[nsh16] <= cin16[0];
            nsh16 <= nsh16 + 1;
        end
        if (en12) begin
            chain12 <= {chain12[10:0], cin12};
            if (nsh12 < 256) log12[nsh12] <= cin12[0];
            nsh12 <= nsh12 + 1;
        end
        if (done16) ndone16 <= ndone16 + 1;
        if (done12) ndone12 <= ndone12 + 1;
        if (bus16.in_valid && bus16.in_ready) acc16 <= acc16 + 1;
        if (bus16.out_valid) ov16 <= ov16 + 1;
        if (bus16.out_valid && bus16.out_ready) begin
            if (nrx16 < 16) rx16[nrx16] <= bus16.out_data;
            nrx16 <= nrx16 + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_load(input bit sel, input logic rb);
        if (sel) begin start12 = 1'b1; rb12 = rb; end
        else     begin start16 = 1'b1; rb16 = rb; end
        tick();
        start12 = 1'b0; start16 = 1'b0; rb12 = 1'b0; rb16 = 1'b0;
        chk("start_busy", sel ? busy12 : busy16, 32'd1);
        chk("start_in_ready", sel ? bus12.in_ready : bus16.in_ready, 32'd1);
    endtask

    task automatic send_word(input bit sel, input logic [7:0] w);
        int n = 0;
        if (sel) begin bus12.in_data = w; bus12.in_valid = 1'b1; end
        else     begin bus16.in_data = w; bus16.in_valid = 1'b1; end
        while (!(sel ? bus12.in_ready : bus16.in_ready) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("send_word_timeout", 32'd0, 32'd1);
        tick();
        bus12.in_valid = 1'b0;
        bus16.in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input string tag);
        int n = 0;
        while (!(sel ? done12 : done16) && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, 32'(n < 200), 32'd1);
        if (n < 200) begin
            chk({tag, "_busy_at_done"}, sel ? busy12 : busy16, 32'd1);
            tick();
            chk({tag, "_done_busy_fall"}, sel ? {done12, busy12} : {done16, busy16}, 32'd0);
        end
    endtask

    initial begin
        int b_sh, b_dn, b_acc, b_ov, b_rx, n;
        start16 = 1'b0; rb16 = 1'b0; start12 = 1'b0; rb12 = 1'b0;
        bus16.in_data = 8'h00; bus16.in_valid = 1'b0; bus16.out_ready = 1'b1;
        bus12.in_data = 8'h00; bus12.in_valid = 1'b0; bus12.out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_ctrl", {en16, cin16, bus16.in_ready, bus16.out_valid, busy16, done16}, 32'd0);
        chk("rst_out_data", bus16.out_data, 32'd0);
        chk("rst_ctrl12", {en12, cin12, bus12.in_ready, busy12, done12}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 12-frame chain: surplus high bits of the second word are dropped
        start_load(1'b1, 1'b0);
        send_word(1'b1, 8'hA5);
        send_word(1'b1, 8'h3C);
        wait_done(1'b1, "c12");
        chk("c12_shifts", nsh12, 32'd12);
        chk("c12_frames", 32'(log12[11:0]), 32'hCA5);
        chk("c12_last4", 32'(log12[11:8]), 32'hC);
        repeat (3) tick();
        chk("c12_done_once", ndone12, 32'd1);

        // Plain load of A5, 3C
        b_sh = nsh16; b_dn = ndone16; b_ov = ov16;
        start_load(1'b0, 1'b0);
        send_word(1'b0, 8'hA5);
        chk("l1_in_ready_shift", bus16.in_ready, 32'd0);
        send_word(1'b0, 8'h3C);
        wait_done(1'b0, "l1");
        repeat (3) tick();
        chk("l1_shifts", nsh16 - b_sh, 32'd16);
        chk("l1_frames", 32'(16'(log16 >> b_sh)), 32'h3CA5);
        chk("l1_done_once", ndone16 - b_dn, 32'd1);
        chk("l1_no_out_valid", ov16 - b_ov, 32'd0);

        // Readback of the loaded chain while loading zeros
        b_sh = nsh16; b_rx = nrx16;
        start_load(1'b0, 1'b1);
        send_word(1'b0, 8'h00);
        send_word(1'b0, 8'h00);
        wait_done(1'b0, "rb1");
        chk("rb1_shifts", nsh16 - b_sh, 32'd16);
        chk("rb1_words", nrx16 - b_rx, 32'd2);
        chk("rb1_word0", rx16[b_rx], 32'hA5);
        chk("rb1_word1", rx16[b_rx + 1], 32'h3C);

        // start and in_valid while shifting: no restart, no extra word
        b_sh = nsh16; b_dn = ndone16; b_acc = acc16;
        start_load(1'b0, 1'b0);
        send_word(1'b0, 8'hA5);
        bus16.in_data = 8'h3C; bus16.in_valid = 1'b1; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        chk("ign_busy", busy16, 32'd1);
        chk("ign_in_ready", bus16.in_ready, 32'd0);
        chk("ign_acc_mid", acc16 - b_acc, 32'd1);
        send_word(1'b0, 8'h3C);
        wait_done(1'b0, "ign");
        repeat (3) tick();
        chk("ign_acc", acc16 - b_acc, 32'd2);
        chk("ign_frames", 32'(16'(log16 >> b_sh)), 32'h3CA5);
        chk("ign_shifts", nsh16 - b_sh, 32'd16);
        chk("ign_done_once", ndone16 - b_dn, 32'd1);

        // Readback with the host stalling the first word for 5 cycles
        b_sh = nsh16; b_rx = nrx16;
        start_load(1'b0, 1'b1);
        send_word(1'b0, 8'h00);
        n = 0;
        while (!bus16.out_valid && n < 50) begin tick(); n++; end
        chk("st_ov_seen", 32'(n < 50), 32'd1);
        bus16.out_ready = 1'b0;
        bus16.in_data = 8'h00; bus16.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("st_config_en", en16, 32'd0);
            chk("st_hold", {bus16.out_valid, bus16.out_data}, 32'h1A5);
            tick();
            bus16.in_valid = 1'b0;
        end
        bus16.out_ready = 1'b1;
        wait_done(1'b0, "st");
        chk("st_shifts", nsh16 - b_sh, 32'd16);
        chk("st_words", nrx16 - b_rx, 32'd2);
        chk("st_word0", rx16[b_rx], 32'hA5);
        chk("st_word1", rx16[b_rx + 1], 32'h3C);
        chk("st_frames", 32'(16'(log16 >> b_sh)), 32'h0000);

        // Reset after the 5th shift abandons the load
        b_sh = nsh16; b_dn = ndone16;
        start_load(1'b0, 1'b0);
        send_word(1'b0, 8'hFF);
        n = 0;
        while ((nsh16 - b_sh) < 5 && n < 50) begin tick(); n++; end
        chk("rs_reached5", nsh16 - b_sh, 32'd5);
        rst_n = 1'b0;
        #1;
        chk("rs_immediate", {en16, busy16, bus16.in_ready, done16}, 32'd0);
        repeat (3) tick();
        chk("rs_no_done", ndone16 - b_dn, 32'd0);
        chk("rs_no_more_shift", nsh16 - b_sh, 32'd5);
        rst_n = 1'b1;
        tick();
        b_sh = nsh16; b_dn = ndone16;
        start_load(1'b0, 1'b0);
        send_word(1'b0, 8'hA5);
        send_word(1'b0, 8'h3C);
        wait_done(1'b0, "rs");
        repeat (2) tick();
        chk("rs_shifts", nsh16 - b_sh, 32'd16);
        chk("rs_frames", 32'(16'(log16 >> b_sh)), 32'h3CA5);
        chk("rs_done_once", ndone16 - b_dn, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
